// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: one load/store at a time over valid/ready,
// with byte/half/word access, sign/zero extension and a fixed response latency.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        busy_o
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req_ready_q, req_ready_d;
   logic            resp_valid_q, resp_valid_d;
   logic            busy_q, busy_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            accept_c;
   logic            err_c;
   logic [AW-1:0]   idx_c;
   logic [31:0]     rd_word_c;
   logic [31:0]     lane_c;
   logic [31:0]     load_c;
   logic [3:0]      be_c;
   logic [31:0]     wdata_c;
   logic            wr_en_c;

   assign accept_c  = req_valid_i & req_ready_q;
   assign idx_c     = req_addr_i[AW+1:2];
   assign rd_word_c = mem_q[idx_c];
   assign lane_c    = rd_word_c >> {req_addr_i[1:0], 3'b000};
   assign wr_en_c   = accept_c & rst & req_we_i & ~err_c;

   // Request decode: error check, load extension and store lane steering
   always_comb begin
      err_c   = (req_addr_i[31:2] >= 30'(DEPTH_WORDS));
      load_c  = rd_word_c;
      be_c    = 4'hF;
      wdata_c = req_wdata_i;
      case (req_size_i)
         2'b00: begin
            load_c  = req_unsigned_i ? {24'b0, lane_c[7:0]} : {{24{lane_c[7]}}, lane_c[7:0]};
            be_c    = 4'b0001 << req_addr_i[1:0];
            wdata_c = {4{req_wdata_i[7:0]}};
         end
         2'b01: begin
            err_c   = err_c | req_addr_i[0];
            load_c  = req_unsigned_i ? {16'b0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
            be_c    = 4'b0011 << {req_addr_i[1], 1'b0};
            wdata_c = {2{req_wdata_i[15:0]}};
         end
         2'b10:   err_c = err_c | (|req_addr_i[1:0]);
         default: err_c = 1'b1;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // WAIT is entered for every latency so resp_valid lands exactly LATENCY edges after accept
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d = WAIT;
               cnt_d   = CW'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - CW'(1);
         end
         RESP: begin
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values; response payload is captured at accept and held
   always_comb begin
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      busy_d       = (state_d != IDLE);
      rdata_d      = rdata_q;
      err_d        = err_q;
      if (accept_c) begin
         rdata_d = (req_we_i | err_c) ? 32'h0 : load_c;
         err_d   = err_c;
      end
   end

   // Store commits at the accept edge; memory has no reset
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
         end
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign busy_o       = busy_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=1 instances share one request stream.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_ready;

   logic        a_req_ready, a_resp_valid, a_resp_err, a_busy;
   logic [31:0] a_resp_rdata;
   logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
   logic [31:0] b_resp_rdata;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(a_req_ready), .req_we_i(req_we),
      .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err), .busy_o(a_busy)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(b_req_ready), .req_we_i(req_we),
      .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err), .busy_o(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   int n_chk;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] er, input logic ee);
      vec_t v;
      v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
      v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   // Called at a negedge with both instances idle; resp_ready held high throughout
   task automatic do_txn(input int id, input vec_t v);
      req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1; resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("v%0d busy after accept", id), 32'(a_busy), 32'd1);
      chk($sformatf("v%0d req_ready after accept", id), 32'(a_req_ready), 32'd0);
      chk($sformatf("v%0d L2 valid k0", id), 32'(a_resp_valid), 32'd0);
      chk($sformatf("v%0d L1 valid k0", id), 32'(b_resp_valid), 32'd0);
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d L2 valid k%0d", id, k), 32'(a_resp_valid), 32'(k == 2));
         chk($sformatf("v%0d L1 valid k%0d", id, k), 32'(b_resp_valid), 32'(k == 1));
         if (k == 2) begin
            chk($sformatf("v%0d L2 rdata", id), a_resp_rdata, v.exp_rdata);
            chk($sformatf("v%0d L2 err", id), 32'(a_resp_err), 32'(v.exp_err));
         end else begin
            chk($sformatf("v%0d L1 rdata", id), b_resp_rdata, v.exp_rdata);
            chk($sformatf("v%0d L1 err", id), 32'(b_resp_err), 32'(v.exp_err));
         end
      end
      @(negedge clk);
      chk($sformatf("v%0d L2 idle", id), 32'(a_req_ready), 32'd1);
      chk($sformatf("v%0d L1 idle", id), 32'(b_req_ready), 32'd1);
   endtask

   localparam int NV = 25;
   vec_t vecs[NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

      //          we    size   u     addr       wdata         exp_rdata     err
      vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
      vecs[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
      vecs[2]  = mk(1'b1, 2'b00, 1'b0, 32'h13,   32'hFFFFFF80, 32'h0,        1'b0);
      vecs[3]  = mk(1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0);
      vecs[4]  = mk(1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h00000080, 1'b0);
      vecs[5]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0);
      vecs[6]  = mk(1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        32'hFFFF80AD, 1'b0);
      vecs[7]  = mk(1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1);
      vecs[8]  = mk(1'b1, 2'b10, 1'b0, 32'h12,   32'h12345678, 32'h0,        1'b1);
      vecs[9]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0);
      vecs[10] = mk(1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1);
      vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'h400,  32'h0,        32'h0,        1'b1);
      vecs[12] = mk(1'b1, 2'b10, 1'b0, 32'h3FC,  32'hCAFEF00D, 32'h0,        1'b0);
      vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h3FC,  32'h0,        32'hCAFEF00D, 1'b0);
      vecs[14] = mk(1'b1, 2'b10, 1'b0, 32'h14,   32'h0,        32'h0,        1'b0);
      vecs[15] = mk(1'b1, 2'b01, 1'b0, 32'h16,   32'hFFFF1234, 32'h0,        1'b0);
      vecs[16] = mk(1'b0, 2'b10, 1'b0, 32'h14,   32'h0,        32'h12340000, 1'b0);
      vecs[17] = mk(1'b0, 2'b01, 1'b1, 32'h16,   32'h0,        32'h00001234, 1'b0);
      vecs[18] = mk(1'b0, 2'b00, 1'b0, 32'h17,   32'h0,        32'h00000012, 1'b0);
      vecs[19] = mk(1'b0, 2'b01, 1'b0, 32'h14,   32'h0,        32'h0,        1'b0);
      vecs[20] = mk(1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        32'hFFFFFFBE, 1'b0);
      vecs[21] = mk(1'b1, 2'b10, 1'b0, 32'h0,    32'h0,        32'h0,        1'b0);
      vecs[22] = mk(1'b1, 2'b10, 1'b0, 32'h400,  32'hFFFFFFFF, 32'h0,        1'b1);
      vecs[23] = mk(1'b0, 2'b10, 1'b0, 32'h0,    32'h0,        32'h0,        1'b0);
      vecs[24] = mk(1'b1, 2'b10, 1'b0, 32'h20,   32'h11223344, 32'h0,        1'b0);

      // Reset state
      #12;
      chk("reset resp_valid", 32'(a_resp_valid), 32'd0);
      chk("reset rdata", a_resp_rdata, 32'h0);
      chk("reset err", 32'(a_resp_err), 32'd0);
      chk("reset busy", 32'(a_busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post-reset req_ready", 32'(a_req_ready), 32'd1);
      chk("post-reset L1 req_ready", 32'(b_req_ready), 32'd1);

      for (int i = 0; i < NV; i++) do_txn(i, vecs[i]);

      // Back-pressure: response held 5 cycles while a second request waits
      req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
      req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h13;
      @(negedge clk);
      chk("stall L1 valid", 32'(b_resp_valid), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall c%0d valid", i), 32'(a_resp_valid), 32'd1);
         chk($sformatf("stall c%0d rdata", i), a_resp_rdata, 32'h80ADBEEF);
         chk($sformatf("stall c%0d err", i), 32'(a_resp_err), 32'd0);
         chk($sformatf("stall c%0d req_ready", i), 32'(a_req_ready), 32'd0);
         if (i < 4) @(negedge clk);
      end
      chk("stall L1 rdata", b_resp_rdata, 32'h80ADBEEF);
      resp_ready = 1'b1;
      @(negedge clk);
      chk("handshake valid drop", 32'(a_resp_valid), 32'd0);
      chk("handshake req_ready", 32'(a_req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("second accept busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      chk("second L2 not early", 32'(a_resp_valid), 32'd0);
      chk("second L1 valid", 32'(b_resp_valid), 32'd1);
      chk("second L1 rdata", b_resp_rdata, 32'h00000080);
      @(negedge clk);
      chk("second L2 valid", 32'(a_resp_valid), 32'd1);
      chk("second L2 rdata", a_resp_rdata, 32'h00000080);
      @(negedge clk);
      chk("second L2 done", 32'(a_req_ready), 32'd1);

      // Reset during WAIT drops the response but keeps committed stores
      req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid-op busy", 32'(a_busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid-op reset valid", 32'(a_resp_valid), 32'd0);
      chk("mid-op reset busy", 32'(a_busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("release req_ready", 32'(a_req_ready), 32'd1);
      chk("release busy", 32'(a_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("dropped resp c%0d", i), 32'(a_resp_valid), 32'd0);
         chk($sformatf("dropped L1 resp c%0d", i), 32'(b_resp_valid), 32'd0);
      end
      do_txn(100, mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0));
      do_txn(101, mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
